// File: rtl/pipe_imem_responder_if.sv
// ----------------------------------------------------------------------------
// pipe_imem_responder_if
// Purpose : bundles the CPU fetch channel and the program-load channel of the
//           instruction-memory responder.
// Signals :
//   pc[31:0]     fetch byte address            (master -> slave)
//   fetch_valid  fetch request                 (master -> slave)
//   fetch_ready  responder accepts a fetch     (slave  -> master)
//   inst[31:0]   fetched instruction word      (slave  -> master)
//   inst_valid   inst is valid this cycle      (slave  -> master)
//   inst_fault   out-of-range / misaligned     (slave  -> master)
//   load_start   begin program load at word 0  (master -> slave)
//   load_data    program word                  (master -> slave)
//   load_valid   load_data is valid            (master -> slave)
//   load_last    final load word               (master -> slave)
//   load_ready   responder accepts a load word (slave  -> master)
//   load_done    one-cycle load-complete pulse (slave  -> master)
// ----------------------------------------------------------------------------
interface pipe_imem_responder_if;
  localparam int unsigned WORD_W = 32;

  // Fetch channel
  logic [WORD_W-1:0] pc;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [WORD_W-1:0] inst;
  logic              inst_valid;
  logic              inst_fault;

  // Program-load channel
  logic              load_start;
  logic [WORD_W-1:0] load_data;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              load_done;

  // CPU / loader side
  modport master (
    output pc, fetch_valid, load_start, load_data, load_valid, load_last,
    input  fetch_ready, inst, inst_valid, inst_fault, load_ready, load_done
  );

  // Responder side
  modport slave (
    input  pc, fetch_valid, load_start, load_data, load_valid, load_last,
    output fetch_ready, inst, inst_valid, inst_fault, load_ready, load_done
  );
endinterface

// File: rtl/pipe_imem_responder.sv
// ----------------------------------------------------------------------------
// pipe_imem_responder
// Purpose : single-ported instruction memory for a pipelined CPU. In IDLE it
//           answers fetches with one-cycle latency; in LOAD it accepts a
//           program stream written from word 0 upward. The two activities are
//           mutually exclusive, so a fetch can never hit a word being written.
// Parameters:
//   DEPTH  number of 32-bit words (power of two, 16..1024)
//   AW     word-index width, log2(DEPTH)
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset (memory contents are preserved)
//   bus    pipe_imem_responder_if.slave: fetch and load channels
// Build option:
//   IMEM_ALIGN_CHECK_EN  when defined, fetches with pc[1:0]!=0 fault;
//                        otherwise pc[1:0] is ignored.
// ----------------------------------------------------------------------------
module pipe_imem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_imem_responder_if.slave   bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]        state_q,       state_d;
  logic [AW-1:0]     ptr_q,         ptr_d;
  logic              fetch_ready_q, fetch_ready_d;
  logic              load_ready_q,  load_ready_d;
  logic              load_done_q,   load_done_d;
  logic [WORD_W-1:0] inst_q,        inst_d;
  logic              inst_valid_q,  inst_valid_d;
  logic              inst_fault_q,  inst_fault_d;

  logic [WORD_W-1:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Fetch address decode
  // --------------------------------------------------------------------------
  logic              fetch_accept_c;
  logic [AW-1:0]     fetch_idx_c;
  logic              out_of_range_c;
  logic              misaligned_c;
  logic              fetch_fault_c;
  logic              mem_we_c;

  assign fetch_accept_c = bus.fetch_valid && fetch_ready_q;
  assign fetch_idx_c    = bus.pc[AW+1:2];
  // Any set bit above the word index puts the address at or past DEPTH*4.
  assign out_of_range_c = |bus.pc[PC_W-1:AW+2];

`ifdef IMEM_ALIGN_CHECK_EN
  assign misaligned_c   = |bus.pc[1:0];
`else
  // Byte offset is deliberately ignored in this build.
  logic unused_pc_lsb_c;
  assign unused_pc_lsb_c = &{1'b0, bus.pc[1:0]};
  assign misaligned_c    = 1'b0;
`endif

  assign fetch_fault_c = out_of_range_c || misaligned_c;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    load_done_d   = 1'b0;
    inst_d        = inst_q;
    inst_valid_d  = 1'b0;
    inst_fault_d  = 1'b0;
    mem_we_c      = 1'b0;
    fetch_ready_d = fetch_ready_q;
    load_ready_d  = load_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        // load_start is ignored here; only the word stream matters.
        if (bus.load_valid) begin
          mem_we_c = 1'b1;
          ptr_d    = ptr_q + AW'(1);
          if (bus.load_last || (ptr_q == LAST_PTR)) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Fetch response: faulting fetches return a nop, idle cycles hold inst.
    if (fetch_accept_c) begin
      inst_valid_d = 1'b1;
      inst_fault_d = fetch_fault_c;
      inst_d       = fetch_fault_c ? '0 : mem_q[fetch_idx_c];
    end

    // Ready flags are registered decodes of the next state.
    fetch_ready_d = (state_d == ST_IDLE);
    load_ready_d  = (state_d == ST_LOAD);
  end

  // --------------------------------------------------------------------------
  // Control / response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      fetch_ready_q <= 1'b1;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      inst_q        <= '0;
      inst_valid_q  <= 1'b0;
      inst_fault_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      fetch_ready_q <= fetch_ready_d;
      load_ready_q  <= load_ready_d;
      load_done_q   <= load_done_d;
      inst_q        <= inst_d;
      inst_valid_q  <= inst_valid_d;
      inst_fault_q  <= inst_fault_d;
    end
  end

  // Program storage: not reset; a reset cycle blocks the write so an aborted
  // load keeps exactly the words accepted before it.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem_q[ptr_q] <= bus.load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.fetch_ready = fetch_ready_q;
  assign bus.load_ready  = load_ready_q;
  assign bus.load_done   = load_done_q;
  assign bus.inst        = inst_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.inst_fault  = inst_fault_q;

endmodule

// File: tb/tb_pipe_imem_responder.sv
// ----------------------------------------------------------------------------
// tb_pipe_imem_responder
// Purpose : self-checking bench for pipe_imem_responder (DEPTH=256). Fetch
//           expectations go into a queue when a fetch is driven and are
//           compared when inst_valid appears. Build with IMEM_ALIGN_CHECK_EN
//           to exercise the alignment-fault variant.
// ----------------------------------------------------------------------------
module tb_pipe_imem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic clk;
  logic rst;

  pipe_imem_responder_if bus_if ();

  pipe_imem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one accepted fetch and record its expected response.
  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    bus_if.fetch_valid = 1'b1;
    bus_if.pc          = pc;
    exp_q.push_back('{inst: ei, fault: ef});
    @(posedge clk); #1;
    bus_if.fetch_valid = 1'b0;
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got inst=%h fault=%b expected no response (t=%0t)",
                   bus_if.inst, bus_if.inst_fault, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_inst", bus_if.inst, mon_e.inst);
          chk("resp_fault", 32'(bus_if.inst_fault), 32'(mon_e.fault));
        end
      end else begin
        chk("idle_fault", 32'(bus_if.inst_fault), 32'h0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{valid: 1'b1, pc: 32'h0000_0000, inst: 32'h2001_0005, fault: 1'b0};
    vecs[1] = '{valid: 1'b1, pc: 32'h0000_0004, inst: 32'h2002_0003, fault: 1'b0};
    vecs[2] = '{valid: 1'b1, pc: 32'h0000_0008, inst: 32'h0022_1820, fault: 1'b0};
    vecs[3] = '{valid: 1'b0, pc: 32'h0000_0000, inst: 32'h0000_0000, fault: 1'b0};
    vecs[4] = '{valid: 1'b1, pc: 32'h0000_0400, inst: 32'h0000_0000, fault: 1'b1};
`ifdef IMEM_ALIGN_CHECK_EN
    vecs[5] = '{valid: 1'b1, pc: 32'h0000_0006, inst: 32'h0000_0000, fault: 1'b1};
`else
    vecs[5] = '{valid: 1'b1, pc: 32'h0000_0006, inst: 32'h2002_0003, fault: 1'b0};
`endif
    vecs[6] = '{valid: 1'b1, pc: 32'hFFFF_FFFC, inst: 32'h0000_0000, fault: 1'b1};
    vecs[7] = '{valid: 1'b1, pc: 32'h0000_0404, inst: 32'h0000_0000, fault: 1'b1};
    vecs[8] = '{valid: 1'b1, pc: 32'h0000_0008, inst: 32'h0022_1820, fault: 1'b0};

    rst               = 1'b1;
    bus_if.pc          = '0;
    bus_if.fetch_valid = 1'b0;
    bus_if.load_start  = 1'b0;
    bus_if.load_data   = '0;
    bus_if.load_valid  = 1'b0;
    bus_if.load_last   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst",        bus_if.inst,              32'h0);
    chk("rst_inst_valid",  32'(bus_if.inst_valid),   32'h0);
    chk("rst_inst_fault",  32'(bus_if.inst_fault),   32'h0);
    chk("rst_load_done",   32'(bus_if.load_done),    32'h0);
    chk("rst_fetch_ready", 32'(bus_if.fetch_ready),  32'h1);
    chk("rst_load_ready",  32'(bus_if.load_ready),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three-word program load ending on load_last
    bus_if.load_start = 1'b1;
    @(posedge clk); #1;
    bus_if.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_last  = (i == 2);
      bus_if.load_data  = (i == 0) ? 32'h2001_0005 : (i == 1) ? 32'h2002_0003 : 32'h0022_1820;
      @(negedge clk);
      chk("load3_ready",      32'(bus_if.load_ready),  32'h1);
      chk("load3_fetch_rdy",  32'(bus_if.fetch_ready), 32'h0);
      chk("load3_done_early", 32'(bus_if.load_done),   32'h0);
      @(posedge clk); #1;
    end
    bus_if.load_valid = 1'b0;
    bus_if.load_last  = 1'b0;
    @(negedge clk);
    chk("load3_done",       32'(bus_if.load_done),   32'h1);
    chk("load3_idle_fetch", 32'(bus_if.fetch_ready), 32'h1);
    chk("load3_idle_load",  32'(bus_if.load_ready),  32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("load3_done_pulse", 32'(bus_if.load_done),   32'h0);
    @(posedge clk); #1;

    // Table-driven fetch vectors, back-to-back with one bubble
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].valid) begin
        drive_fetch(vecs[i].pc, vecs[i].inst, vecs[i].fault);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("inst_hold",       bus_if.inst,            32'h0022_1820);
    chk("inst_hold_valid", 32'(bus_if.inst_valid), 32'h0);
    @(posedge clk); #1;

    // Fetch coinciding with load_start: fetch completes, FSM enters LOAD
    bus_if.load_start = 1'b1;
    drive_fetch(32'h0000_0004, 32'h2002_0003, 1'b0);
    bus_if.load_start = 1'b0;
    @(negedge clk);
    chk("coinc_load_ready",  32'(bus_if.load_ready),  32'h1);
    chk("coinc_fetch_ready", 32'(bus_if.fetch_ready), 32'h0);
    @(posedge clk); #1;

    // Full-depth load without load_last; a fetch and a repeated load_start
    // during the first word must both be ignored
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus_if.load_valid  = 1'b1;
      bus_if.load_data   = 32'hA000_0000 + 32'(i);
      bus_if.fetch_valid = (i == 0);
      bus_if.load_start  = (i == 0);
      bus_if.pc          = 32'h0;
      @(negedge clk);
      chk("full_done_early", 32'(bus_if.load_done), 32'h0);
      @(posedge clk); #1;
    end
    bus_if.load_valid  = 1'b0;
    bus_if.fetch_valid = 1'b0;
    bus_if.load_start  = 1'b0;
    @(negedge clk);
    chk("full_done",       32'(bus_if.load_done),   32'h1);
    chk("full_idle_fetch", 32'(bus_if.fetch_ready), 32'h1);
    @(posedge clk); #1;
    drive_fetch(32'h0000_03FC, 32'hA000_00FF, 1'b0);
    drive_fetch(32'h0000_0000, 32'hA000_0000, 1'b0);
    drive_fetch(32'h0000_0004, 32'hA000_0001, 1'b0);

    // Second load aborted by reset after two words
    bus_if.load_start = 1'b1;
    @(posedge clk); #1;
    bus_if.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = 32'hB000_0000 + 32'(i);
      @(negedge clk);
      chk("abort_done_early", 32'(bus_if.load_done), 32'h0);
      @(posedge clk); #1;
    end
    bus_if.load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done_pre", 32'(bus_if.load_done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_done",        32'(bus_if.load_done),   32'h0);
    chk("abort_fetch_ready", 32'(bus_if.fetch_ready), 32'h1);
    chk("abort_load_ready",  32'(bus_if.load_ready),  32'h0);
    chk("abort_inst",        bus_if.inst,             32'h0);
    chk("abort_inst_valid",  32'(bus_if.inst_valid),  32'h0);
    @(posedge clk); #1;
    drive_fetch(32'h0000_0000, 32'hB000_0000, 1'b0);
    drive_fetch(32'h0000_0004, 32'hB000_0001, 1'b0);
    drive_fetch(32'h0000_0008, 32'hA000_0002, 1'b0);
    drive_fetch(32'h0000_03FC, 32'hA000_00FF, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_imem_responder.md
PIPE_IMEM_RESPONDER -- requirements
Module: pipe_imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit instruction words (power of two, 16..1024).
REQ-002 SHALL have parameter AW, default 8, word-index width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pc  input  32  fetch byte address from the CPU.
REQ-006 SHALL have port fetch_valid  input  1  CPU fetch request.
REQ-007 SHALL have port fetch_ready  output  1  responder can accept a fetch this cycle.
REQ-008 SHALL have port inst  output  32  fetched instruction word.
REQ-009 SHALL have port inst_valid  output  1  inst is valid this cycle.
REQ-010 SHALL have port inst_fault  output  1  fetch was out of range or misaligned; inst forced to 0 (nop).
REQ-011 SHALL have port load_start  input  1  begin a program load at word 0.
REQ-012 SHALL have port load_data  input  32  program word.
REQ-013 SHALL have port load_valid  input  1  load_data is valid.
REQ-014 SHALL have port load_last  input  1  current load word is the final one.
REQ-015 SHALL have port load_ready  output  1  responder accepts a load word.
REQ-016 SHALL have port load_done  output  1  one-cycle pulse when a load completes.

Function
REQ-017 SHALL implement FSM states IDLE and LOAD; fetch is served only in IDLE.
- IDLE: fetch_ready=1, load_ready=0.
- LOAD: fetch_ready=0, load_ready=1.
REQ-018 In IDLE, load_start=1 SHALL move to LOAD next cycle with the load pointer at 0.
REQ-019 In LOAD, each load_valid=1 cycle SHALL write load_data to mem[ptr] and increment ptr.
REQ-020 LOAD SHALL return to IDLE and pulse load_done for one cycle after the accepted word carrying load_last=1, or after the word written at ptr=DEPTH-1, whichever comes first.
REQ-021 load_start in LOAD SHALL be ignored.
REQ-022 A fetch is accepted when fetch_valid=1 and fetch_ready=1; inst, inst_valid and inst_fault SHALL update on the next edge (latency 1, one response per accepted fetch, back-to-back every cycle).
REQ-023 inst SHALL be mem[pc[AW+1:2]] when pc < DEPTH*4; otherwise inst=0 and inst_fault=1.
REQ-024 A cycle with no accepted fetch SHALL drive inst_valid=0 and inst_fault=0 on the next edge; inst holds its last value.
REQ-025 If load_start and an accepted fetch coincide in IDLE, the fetch SHALL complete normally next cycle and the FSM SHALL enter LOAD.
REQ-026 A fetch to an address written in the same cycle is impossible by construction (mutually exclusive states).

Reset
REQ-027 rst SHALL force state IDLE, ptr=0, inst=0, inst_valid=0, inst_fault=0, load_done=0 on the next edge.
REQ-028 Memory contents SHALL NOT be cleared by rst; rst during LOAD SHALL abort the load with no load_done, keeping words already written.

Configuration
REQ-029 With macro IMEM_ALIGN_CHECK_EN defined, a fetch with pc[1:0]!=0 SHALL return inst=0 and inst_fault=1.
REQ-030 Without IMEM_ALIGN_CHECK_EN, pc[1:0] SHALL be ignored and inst_fault SHALL flag only out-of-range fetches.

Verification
REQ-031 Reset, load 3 words 0x20010005, 0x20020003, 0x00221820 with load_last on word 3 -> load_ready=1 three cycles, load_done pulse 1 cycle after word 3, state IDLE.
REQ-032 Fetch pc=0,4,8 on consecutive cycles -> inst 0x20010005, 0x20020003, 0x00221820 with inst_valid=1 on the three following cycles, inst_fault=0.
REQ-033 Fetch pc=DEPTH*4 (0x400) -> next cycle inst=0, inst_valid=1, inst_fault=1.
REQ-034 Fetch pc=0x6 -> with IMEM_ALIGN_CHECK_EN: inst=0, inst_fault=1; without: inst=0x20020003, inst_fault=0.
REQ-035 Load DEPTH words without load_last, assert rst mid-second-load after 2 words -> load_done only at word DEPTH-1 of first load; after rst: state IDLE, fetch pc=0 returns the second load's word 0.
